// File: rtl/decoder_2to4.sv
// decoder_2to4: 2-to-4 decoder with combinational one-hot outputs, a registered
// one-hot copy, a change-detect pulse and optional per-code hit counters.
// Optional feature macro: DECODER_HIT_CNT_EN enables the saturating hit counters;
// without it the HIT_CNT_* outputs are constant zero and CNT_CLR is ignored.
module decoder_2to4 #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       VAL_IN,
  input  logic             EN,
  input  logic             CNT_CLR,
  output logic             VAL_00,
  output logic             VAL_01,
  output logic             VAL_10,
  output logic             VAL_11,
  output logic [3:0]       ONEHOT_Q,
  output logic             CHANGED,
  output logic [CNT_W-1:0] HIT_CNT_00,
  output logic [CNT_W-1:0] HIT_CNT_01,
  output logic [CNT_W-1:0] HIT_CNT_10,
  output logic [CNT_W-1:0] HIT_CNT_11
);

  logic [1:0] prev_code;
  logic       first_seen;
  logic [3:0] onehot_now;

  // The decode is pure logic on VAL_IN so it works with no clock and ignores reset.
  assign VAL_00     = (VAL_IN == 2'b00);
  assign VAL_01     = (VAL_IN == 2'b01);
  assign VAL_10     = (VAL_IN == 2'b10);
  assign VAL_11     = (VAL_IN == 2'b11);
  assign onehot_now = {VAL_11, VAL_10, VAL_01, VAL_00};

  // Sample register: captures the decode and flags a code change on enabled
  // cycles; the first sample after reset never counts as a change, and any
  // idle cycle drops the pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ONEHOT_Q   <= 4'b0000;
      CHANGED    <= 1'b0;
      prev_code  <= 2'b00;
      first_seen <= 1'b0;
    end else if (EN) begin
      ONEHOT_Q   <= onehot_now;
      CHANGED    <= first_seen && (VAL_IN != prev_code);
      prev_code  <= VAL_IN;
      first_seen <= 1'b1;
    end else begin
      CHANGED    <= 1'b0;
    end
  end

`ifdef DECODER_HIT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] hit_cnt [4];

  // Hit counters: reset beats clear, clear beats a same-cycle hit, and the
  // selected counter sticks at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RST || CNT_CLR) begin
      for (int i = 0; i < 4; i++) begin
        hit_cnt[i] <= '0;
      end
    end else if (EN && (hit_cnt[VAL_IN] != CNT_MAX)) begin
      hit_cnt[VAL_IN] <= hit_cnt[VAL_IN] + CNT_W'(1);
    end
  end

  assign HIT_CNT_00 = hit_cnt[0];
  assign HIT_CNT_01 = hit_cnt[1];
  assign HIT_CNT_10 = hit_cnt[2];
  assign HIT_CNT_11 = hit_cnt[3];
`else
  logic unused_cnt_clr;

  // Counters are compiled out; the clear input is deliberately left unused.
  assign unused_cnt_clr = CNT_CLR;
  assign HIT_CNT_00     = '0;
  assign HIT_CNT_01     = '0;
  assign HIT_CNT_10     = '0;
  assign HIT_CNT_11     = '0;
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// tb_decoder_2to4: self-checking bench for decoder_2to4 with a behavioural
// reference model; counter expectations follow DECODER_HIT_CNT_EN.
module tb_decoder_2to4;

  localparam int W = 2;
  localparam int CNT_MAX = (1 << W) - 1;

  logic         CLK;
  logic         RST;
  logic [1:0]   VAL_IN;
  logic         EN;
  logic         CNT_CLR;
  logic         VAL_00, VAL_01, VAL_10, VAL_11;
  logic [3:0]   ONEHOT_Q;
  logic         CHANGED;
  logic [W-1:0] HIT_CNT_00, HIT_CNT_01, HIT_CNT_10, HIT_CNT_11;

  logic         clk_run;
  int           total;
  int           bad;

  // reference model state
  logic [3:0]   m_onehot;
  logic         m_changed;
  int           m_prev;
  logic         m_seen;
  int           m_cnt [4];

  decoder_2to4 #(.CNT_W(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .VAL_IN     (VAL_IN),
    .EN         (EN),
    .CNT_CLR    (CNT_CLR),
    .VAL_00     (VAL_00),
    .VAL_01     (VAL_01),
    .VAL_10     (VAL_10),
    .VAL_11     (VAL_11),
    .ONEHOT_Q   (ONEHOT_Q),
    .CHANGED    (CHANGED),
    .HIT_CNT_00 (HIT_CNT_00),
    .HIT_CNT_01 (HIT_CNT_01),
    .HIT_CNT_10 (HIT_CNT_10),
    .HIT_CNT_11 (HIT_CNT_11)
  );

  // clock held low until the combinational test is done
  initial begin
    CLK = 1'b0;
    wait (clk_run);
    forever #5 CLK = ~CLK;
  end

  function automatic logic [4*W-1:0] exp_cnt();
    return {W'(m_cnt[3]), W'(m_cnt[2]), W'(m_cnt[1]), W'(m_cnt[0])};
  endfunction

  function automatic logic [4*W-1:0] act_cnt();
    return {HIT_CNT_11, HIT_CNT_10, HIT_CNT_01, HIT_CNT_00};
  endfunction

  // reference model: what one rising edge does to the visible state
  task automatic model_step(input logic rst, input logic en, input logic clr, input logic [1:0] code);
    if (rst) begin
      m_onehot  = 4'b0000;
      m_changed = 1'b0;
      m_prev    = 0;
      m_seen    = 1'b0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      if (en) begin
        m_changed = m_seen && (int'(code) != m_prev);
        m_onehot  = 4'(1 << code);
        m_prev    = int'(code);
        m_seen    = 1'b1;
      end else begin
        m_changed = 1'b0;
      end
`ifdef DECODER_HIT_CNT_EN
      if (clr) begin
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (en && m_cnt[code] < CNT_MAX) begin
        m_cnt[code] = m_cnt[code] + 1;
      end
`endif
    end
  endtask

  // drive inputs on the falling edge, then settle #1 past the rising edge
  task automatic drive_edge(input logic rst, input logic en, input logic clr, input logic [1:0] code);
    @(negedge CLK);
    RST = rst; EN = en; CNT_CLR = clr; VAL_IN = code;
    @(posedge CLK);
    model_step(rst, en, clr, code);
    #1;
  endtask

  task automatic test_comb();
    logic [1:0] code;
    for (int i = 0; i < 4; i++) begin
      code = 2'(i);
      VAL_IN = code;
      #1;
      total++;
      if ({VAL_11, VAL_10, VAL_01, VAL_00} !== 4'(1 << i)) begin
        bad++;
        $display("[TB] FAIL comb_decode code=%0d got=%b want=%b", i, {VAL_11, VAL_10, VAL_01, VAL_00}, 4'(1 << i));
      end
    end
  endtask

  task automatic test_reset();
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00);
    total++;
    if (ONEHOT_Q !== 4'b0000 || CHANGED !== 1'b0 || act_cnt() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got onehot=%b chg=%b cnt=%h want 0000/0/0", ONEHOT_Q, CHANGED, act_cnt());
    end
  endtask

  task automatic test_first_sample();
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00);
    drive_edge(1'b0, 1'b1, 1'b0, 2'b10);
    total++;
    if (ONEHOT_Q !== 4'b0100 || CHANGED !== 1'b0) begin
      bad++;
      $display("[TB] FAIL first_sample got onehot=%b chg=%b want 0100/0", ONEHOT_Q, CHANGED);
    end
  endtask

  task automatic test_changed_seq();
    logic [1:0] codes [3];
    logic       want_chg [3];
    codes = '{2'b01, 2'b01, 2'b11};
    want_chg = '{1'b0, 1'b0, 1'b1};
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, 1'b1, 1'b0, codes[i]);
      total++;
      if (CHANGED !== want_chg[i]) begin
        bad++;
        $display("[TB] FAIL changed_seq step=%0d got=%b want=%b", i, CHANGED, want_chg[i]);
      end
    end
    total++;
    if (ONEHOT_Q !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL changed_seq_onehot got=%b want=1000", ONEHOT_Q);
    end
  endtask

  task automatic test_en_hold();
    drive_edge(1'b0, 1'b1, 1'b0, 2'b01);
    drive_edge(1'b0, 1'b1, 1'b0, 2'b10);
    drive_edge(1'b0, 1'b0, 1'b0, 2'b11);
    total++;
    if (ONEHOT_Q !== m_onehot || CHANGED !== 1'b0 || act_cnt() !== exp_cnt()) begin
      bad++;
      $display("[TB] FAIL en_hold got onehot=%b chg=%b cnt=%h want %b/0/%h", ONEHOT_Q, CHANGED, act_cnt(), m_onehot, exp_cnt());
    end
  endtask

  task automatic test_saturation();
    drive_edge(1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 5; i++) drive_edge(1'b0, 1'b1, 1'b0, 2'b00);
    total++;
    if (act_cnt() !== exp_cnt()) begin
      bad++;
      $display("[TB] FAIL saturation got cnt=%h want=%h", act_cnt(), exp_cnt());
    end
  endtask

  task automatic test_clear();
    drive_edge(1'b0, 1'b1, 1'b0, 2'b10);
    drive_edge(1'b0, 1'b1, 1'b1, 2'b11);
    total++;
    if (act_cnt() !== '0 || CHANGED !== 1'b1 || ONEHOT_Q !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL clear_with_hit got cnt=%h chg=%b onehot=%b want 0/1/1000", act_cnt(), CHANGED, ONEHOT_Q);
    end
    drive_edge(1'b0, 1'b1, 1'b0, 2'b11);
    drive_edge(1'b0, 1'b0, 1'b1, 2'b01);
    total++;
    if (act_cnt() !== '0 || ONEHOT_Q !== 4'b1000 || CHANGED !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_idle got cnt=%h onehot=%b chg=%b want 0/1000/0", act_cnt(), ONEHOT_Q, CHANGED);
    end
  endtask

  task automatic test_reset_priority();
    drive_edge(1'b0, 1'b1, 1'b0, 2'b01);
    drive_edge(1'b0, 1'b1, 1'b0, 2'b10);
    drive_edge(1'b1, 1'b1, 1'b1, 2'b11);
    total++;
    if (ONEHOT_Q !== 4'b0000 || CHANGED !== 1'b0 || act_cnt() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_priority got onehot=%b chg=%b cnt=%h want 0000/0/0", ONEHOT_Q, CHANGED, act_cnt());
    end
    total++;
    if ({VAL_11, VAL_10, VAL_01, VAL_00} !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL comb_during_reset got=%b want=1000", {VAL_11, VAL_10, VAL_01, VAL_00});
    end
    drive_edge(1'b0, 1'b1, 1'b0, 2'b01);
    total++;
    if (CHANGED !== 1'b0 || ONEHOT_Q !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL post_reset_first got chg=%b onehot=%b want 0/0010", CHANGED, ONEHOT_Q);
    end
  endtask

  task automatic test_random();
    logic       r_rst, r_en, r_clr;
    logic [1:0] r_code;
    for (int n = 0; n < 300; n++) begin
      r_rst  = ($urandom_range(0, 29) == 0);
      r_en   = ($urandom_range(0, 3) != 0);
      r_clr  = ($urandom_range(0, 11) == 0);
      r_code = 2'($urandom_range(0, 3));
      drive_edge(r_rst, r_en, r_clr, r_code);
      total++;
      if (ONEHOT_Q !== m_onehot || CHANGED !== m_changed || act_cnt() !== exp_cnt()
          || {VAL_11, VAL_10, VAL_01, VAL_00} !== 4'(1 << r_code)) begin
        bad++;
        $display("[TB] FAIL random n=%0d got onehot=%b chg=%b cnt=%h dec=%b want %b/%b/%h/%b", n,
                 ONEHOT_Q, CHANGED, act_cnt(), {VAL_11, VAL_10, VAL_01, VAL_00},
                 m_onehot, m_changed, exp_cnt(), 4'(1 << r_code));
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    clk_run = 1'b0;
    RST = 1'b0; EN = 1'b0; CNT_CLR = 1'b0; VAL_IN = 2'b00;
    m_onehot = 4'b0000; m_changed = 1'b0; m_prev = 0; m_seen = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;

    test_comb();
    clk_run = 1'b1;
    test_reset();
    test_first_sample();
    test_changed_seq();
    test_en_hold();
    test_saturation();
    test_clear();
    test_reset_priority();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
